switch_input_bank: RTL and testbench
====================================

// Module: switch_input_bank
// PURPOSE
//  Memory-mapped, parametrised switch peripheral on the 8-bit microprocessor bus.
//  Synchronises and debounces NUM_BANKS x 8 switch inputs and exposes each bank's stable value.
//  Latches per-bit change events in write-1-to-clear status registers.
//  Raises an interrupt with an ack handshake to the processor's IRQ controller.
// PARAMETERS
//  BASE_ADDR   8'h80   first bus address of the register window
//  NUM_BANKS   2       8-bit switch banks, 1..8
//  DEB_TICKS   50000   CLK cycles per debounce sample tick, >=2; counter width = $clog2(DEB_TICKS)
// PORTS
//  CLK        in     1            system clock
//  RST        in     1            synchronous, active-high reset
//  BUS_ADDR   in     8            processor address bus
//  BUS_DATA   inout  8            processor data bus; driven only during a read of this block, else Z
//  BUS_WE     in     1            bus write enable: 1 = write, 0 = read
//  SWITCH_IN  in     8*NUM_BANKS  raw asynchronous switch pins; bank b = [8b+7:8b]
//  IRQ        out    1            interrupt request, level
//  IRQ_ACK    in     1            interrupt acknowledge, 1-cycle pulse
// BEHAVIOUR
//  Register map, offset from BASE_ADDR; N = NUM_BANKS:
//   0..N-1  VAL[b]  RO   debounced value of bank b
//   N..2N-1 CHG[b]  W1C  change latch of bank b
//   2N      CTRL    RW   bit0 IRQ enable; bit1 edge mode (0 = both edges, 1 = rising only);
//                        bits 7:2 read 0
//  Any address outside BASE_ADDR..BASE_ADDR+2N: no drive, no side effect.
//  Read: address decoded at CLK edge k; BUS_DATA driven with the registered value from cycle k+1
//   for exactly one cycle; Z otherwise, including cycles with BUS_WE=1.
//  Write: sampled at the CLK edge where BUS_WE=1 and the address hits.
//   - Writes to VAL are ignored.
//   - CHG: each bit written 1 is cleared.
//  Input path: 2-flop synchroniser per pin -> prescaler -> debouncer.
//   - Prescaler counts 0..DEB_TICKS-1 and emits a 1-cycle tick at wrap.
//   - On each tick a bit's stable value updates only if its two most recent tick samples agree.
//   - Pin-to-VAL latency: 2 sync cycles + 2..3 ticks.
//  Edge event: a stable bit changes, qualified by edge mode; the corresponding CHG bit is set.
//   - Same-cycle W1C and new event on one bit: event wins, bit stays 1.
//  IRQ:
//   - Set on the cycle after any new event while CTRL.bit0=1.
//   - Cleared on the cycle after IRQ_ACK=1.
//   - Ack and new event in the same cycle: IRQ stays 1.
//   - Enable 1->0 clears IRQ next cycle. CHG bits are unaffected.
//   - IRQ_ACK while IRQ=0: no effect.
//  Reset, also mid-operation:
//   - Cleared to 0: VAL, CHG, CTRL, IRQ, synchronisers, sample history, prescaler.
//   - BUS_DATA = Z.
//   - No events are generated from reset values: first-tick agreement loads silently.
// STRUCTURE
//  Shared package sw_bank_pkg:
//   - register offset constants: VAL_OFS, CHG_OFS(N), CTRL_OFS(N)
//   - CTRL bit indices; DEB_TICKS default
//  Sub-module switch_debouncer: one 8-bit bank per instance.
//   - Contains: sync flops, sample history, stable register, edge detect.
//   - Driven by the shared tick; instantiated NUM_BANKS times in a generate loop.
//  Top level holds: prescaler, address decode, CHG/CTRL registers, IRQ FSM (IDLE/PEND), bus tristate.
// TESTING
//  All tests: DEB_TICKS=4, NUM_BANKS=2.
//  1. Reset then read 0x80..0x84
//     -> all read 8'h00 one cycle after the address; BUS_DATA=Z otherwise.
//  2. SWITCH_IN=16'hA503 held
//     -> VAL0=8'h03, VAL1=8'hA5 within 2 + 3*4 cycles; CHG0=8'h03, CHG1=8'hA5.
//  3. Bit0 glitch 1 cycle (shorter than a tick), CTRL=8'h01
//     -> VAL0 unchanged; CHG0 unchanged; IRQ stays 0.
//  4. CTRL=8'h03, bank0 bit2 0->1->0
//     -> CHG0 bit2 set on the rise only; IRQ=1.
//     -> IRQ_ACK pulse: IRQ=0 next cycle; write 8'h04 to 0x82: CHG0=0.
//  5. W1C to 0x82 in the same cycle as a new bit2 event
//     -> CHG0 bit2 remains 1.
//     -> IRQ_ACK coincident with the event: IRQ remains 1.
//  6. RST asserted mid-debounce with a pending IRQ
//     -> next cycle: IRQ=0, all registers 0, BUS_DATA=Z.
//     -> held inputs re-debounce without setting CHG.

Source files
------------

// File: rtl/sw_bank_pkg.sv
// sw_bank_pkg: register map offsets, control bit positions and IRQ states shared by the switch bank
package sw_bank_pkg;
  localparam int VAL_OFS        = 0;
  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_RISE_ONLY = 1;
  localparam int DEB_TICKS_DEF  = 50000;
  typedef enum logic {IDLE, PEND} irq_state_t;
  function automatic int CHG_OFS(input int n);
    return n;
  endfunction
  function automatic int CTRL_OFS(input int n);
    return 2 * n;
  endfunction
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise, tick-sample debounce and edge-detect one 8-bit switch bank
module switch_debouncer
  import sw_bank_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_tick,
  input  logic       i_rise_only,
  input  logic [7:0] i_pins,
  output logic [7:0] o_val,
  output logic [7:0] o_evt
);
  logic [7:0] r_sync1, r_sync2, r_smp0, r_smp1, r_stable;
  logic [1:0] r_nsmp;
  logic       r_loaded;
  logic [7:0] w_agree, w_next, w_chg;
  logic       w_judge;
  // a bit is only judged once two real samples exist since reset; the first judgement loads silently
  assign w_judge = i_tick && r_nsmp == 2'd2;
  assign w_agree = ~(r_smp0 ^ r_smp1);
  assign w_next  = w_judge ? (w_agree & r_smp0) | (~w_agree & r_stable) : r_stable;
  assign w_chg   = r_loaded ? (w_next ^ r_stable) : 8'h00;
  assign o_evt   = w_chg & (i_rise_only ? w_next : 8'hFF);
  assign o_val   = r_stable;
  // two-flop synchroniser against metastability on the raw pins
  always_ff @(posedge CLK) begin
    r_sync1 <= RST ? 8'h00 : i_pins;
    r_sync2 <= RST ? 8'h00 : r_sync1;
  end
  // tick sample history and stable value
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp0   <= 8'h00;
      r_smp1   <= 8'h00;
      r_stable <= 8'h00;
      r_nsmp   <= 2'd0;
      r_loaded <= 1'b0;
    end else begin
      r_stable <= w_next;
      if (w_judge) r_loaded <= 1'b1;
      if (i_tick) begin
        r_smp0 <= r_sync2;
        r_smp1 <= r_smp0;
        r_nsmp <= r_nsmp == 2'd2 ? 2'd2 : r_nsmp + 2'd1;
      end
    end
  end
endmodule

// File: rtl/switch_input_bank.sv
// switch_input_bank: bus-mapped debounced switch banks with W1C change latches and acked IRQ
module switch_input_bank
  import sw_bank_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h80,
  parameter int         NUM_BANKS = 2,
  parameter int         DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             BUS_ADDR,
  inout  logic [7:0]             BUS_DATA,
  input  logic                   BUS_WE,
  input  logic [8*NUM_BANKS-1:0] SWITCH_IN,
  output logic                   IRQ,
  input  logic                   IRQ_ACK
);
  localparam int N  = NUM_BANKS;
  localparam int CW = $clog2(DEB_TICKS);
  logic [CW-1:0]  r_pre;
  logic           w_tick, w_hit, w_wr, r_rd_en;
  logic [8*N-1:0] w_val, w_evt, w_clr, r_chg;
  logic [1:0]     r_ctrl;
  logic [7:0]     w_ofs, r_rd_ofs, w_rd_data;
  irq_state_t     r_state, w_state_nxt;
  assign w_tick = r_pre == CW'(DEB_TICKS - 1);
  assign w_ofs  = BUS_ADDR - BASE_ADDR;
  assign w_hit  = BUS_ADDR >= BASE_ADDR && int'(w_ofs) <= CTRL_OFS(N);
  assign w_wr   = w_hit && BUS_WE;
  // prescaler producing the shared debounce sample tick
  always_ff @(posedge CLK) r_pre <= (RST || w_tick) ? '0 : r_pre + CW'(1);
  for (genvar b = 0; b < N; b++) begin : g_bank
    switch_debouncer u_deb (
      .CLK        (CLK),
      .RST        (RST),
      .i_tick     (w_tick),
      .i_rise_only(r_ctrl[CTRL_RISE_ONLY]),
      .i_pins     (SWITCH_IN[8*b+:8]),
      .o_val      (w_val[8*b+:8]),
      .o_evt      (w_evt[8*b+:8])
    );
    assign w_clr[8*b+:8] = (w_wr && int'(w_ofs) == CHG_OFS(N) + b) ? BUS_DATA : 8'h00;
  end
  // change latches (a new event beats a same-cycle clear) and control register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chg  <= '0;
      r_ctrl <= 2'b00;
    end else begin
      r_chg <= (r_chg & ~w_clr) | w_evt;
      if (w_wr && int'(w_ofs) == CTRL_OFS(N)) r_ctrl <= BUS_DATA[1:0];
    end
  end
  // remember a read hit so its data is presented for exactly the following cycle
  always_ff @(posedge CLK) begin
    r_rd_en  <= !RST && w_hit && !BUS_WE;
    r_rd_ofs <= RST ? 8'h00 : w_ofs;
  end
  // read data mux over the register window
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (int'(r_rd_ofs) == VAL_OFS + i) w_rd_data = w_val[8*i+:8];
      if (int'(r_rd_ofs) == CHG_OFS(N) + i) w_rd_data = r_chg[8*i+:8];
    end
    if (int'(r_rd_ofs) == CTRL_OFS(N)) w_rd_data = {6'b0, r_ctrl};
  end
  assign BUS_DATA = (r_rd_en && !BUS_WE) ? w_rd_data : 8'hzz;
  // IRQ state register
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_state_nxt;
  // disable dominates, then a new event, then the acknowledge
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = !r_ctrl[CTRL_IRQ_EN] ? IDLE : |w_evt ? PEND : IRQ_ACK ? IDLE : r_state;
  end
  assign IRQ = r_state == PEND;
endmodule

// File: tb/tb_switch_input_bank.sv
// tb_switch_input_bank: directed vectors, read-data scoreboard and IRQ checks for switch_input_bank
`timescale 1ns/1ps
module tb_switch_input_bank;
  logic        clk = 1'b0, rst = 1'b1, bus_we = 1'b0, irq_ack = 1'b0, irq;
  logic [7:0]  addr = 8'h00, wdata = 8'h00;
  logic [15:0] sw = 16'h0000;
  logic        drv = 1'b0, rd_req = 1'b0, rd_pend = 1'b0;
  tri1 [7:0]   bus_data;
  int          checks = 0, errors = 0, tb_pre = 0;
  typedef struct { string name; logic [7:0] exp; } exp_t;
  exp_t q[$];
  assign bus_data = drv ? wdata : 8'hzz;
  switch_input_bank #(.BASE_ADDR(8'h80), .NUM_BANKS(2), .DEB_TICKS(4)) dut (
    .CLK(clk), .RST(rst), .BUS_ADDR(addr), .BUS_DATA(bus_data), .BUS_WE(bus_we),
    .SWITCH_IN(sw), .IRQ(irq), .IRQ_ACK(irq_ack)
  );
  always #5 clk = ~clk;
  // tick phase tracker used only to place stimulus on a known tick boundary
  always @(posedge clk) tb_pre <= (rst || tb_pre == 3) ? 0 : tb_pre + 1;
  always @(posedge clk) rd_pend <= rd_req;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // monitor: pops the expected read data in the slot after each read; otherwise the bus must be released
  always @(negedge clk) begin
    if (rd_pend) begin
      if (q.size() == 0) chk("scoreboard_underflow", 8'h01, 8'h00);
      else begin
        exp_t e;
        e = q.pop_front();
        chk(e.name, bus_data, e.exp);
      end
    end else if (!drv) chk("bus_release", bus_data, 8'hFF);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
    addr = a; bus_we = 1'b0; rd_req = 1'b1;
    q.push_back('{name: n, exp: e});
    cyc(1);
    rd_req = 1'b0; addr = 8'h00;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1);
    addr = a; wdata = d; bus_we = 1'b1; drv = 1'b1;
    cyc(1);
    addr = 8'h00; bus_we = 1'b0; drv = 1'b0;
  endtask
  task automatic chk_irq(input string n, input logic e);
    @(negedge clk);
    chk(n, {7'b0, irq}, {7'b0, e});
  endtask
  task automatic wait_tick();
    do cyc(1); while (tb_pre != 0);
  endtask
  initial begin
    // reset state and address window boundaries
    cyc(3);
    rst = 1'b0;
    rd(8'h80, 8'h00, "rst_val0");
    rd(8'h81, 8'h00, "rst_val1");
    rd(8'h82, 8'h00, "rst_chg0");
    rd(8'h83, 8'h00, "rst_chg1");
    rd(8'h84, 8'h00, "rst_ctrl");
    rd(8'h85, 8'hFF, "above_window");
    rd(8'h7F, 8'hFF, "below_window");
    chk_irq("rst_irq", 1'b0);
    cyc(20);
    // held pattern debounces into VAL and latches CHG, IRQ disabled
    sw = 16'hA503;
    cyc(20);
    rd(8'h80, 8'h03, "val0_a503");
    rd(8'h81, 8'hA5, "val1_a503");
    rd(8'h82, 8'h03, "chg0_a503");
    rd(8'h83, 8'hA5, "chg1_a503");
    chk_irq("irq_disabled", 1'b0);
    wr(8'h82, 8'hFF);
    wr(8'h83, 8'hFF);
    wr(8'h80, 8'h55);
    rd(8'h82, 8'h00, "chg0_cleared");
    rd(8'h83, 8'h00, "chg1_cleared");
    rd(8'h80, 8'h03, "val0_ro");
    // one-cycle glitch is filtered
    wr(8'h84, 8'h01);
    sw = 16'hA502;
    cyc(1);
    sw = 16'hA503;
    cyc(20);
    rd(8'h80, 8'h03, "glitch_val0");
    rd(8'h82, 8'h00, "glitch_chg0");
    rd(8'h84, 8'h01, "ctrl_en");
    chk_irq("glitch_irq", 1'b0);
    // rising-only mode, ack and W1C
    wr(8'h84, 8'h07);
    rd(8'h84, 8'h03, "ctrl_rsvd_zero");
    sw = 16'hA507;
    cyc(20);
    rd(8'h82, 8'h04, "chg0_rise");
    rd(8'h80, 8'h07, "val0_rise");
    chk_irq("irq_rise", 1'b1);
    sw = 16'hA503;
    cyc(20);
    rd(8'h82, 8'h04, "chg0_no_fall");
    rd(8'h80, 8'h03, "val0_fall");
    chk_irq("irq_held", 1'b1);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    chk_irq("irq_acked", 1'b0);
    wr(8'h82, 8'h04);
    rd(8'h82, 8'h00, "chg0_w1c");
    // W1C and ack coincident with a new event: event wins
    wait_tick();
    sw = 16'hA507;
    cyc(11);
    addr = 8'h82; wdata = 8'h04; bus_we = 1'b1; drv = 1'b1; irq_ack = 1'b1;
    cyc(1);
    addr = 8'h00; bus_we = 1'b0; drv = 1'b0; irq_ack = 1'b0;
    chk_irq("irq_ack_vs_event", 1'b1);
    rd(8'h82, 8'h04, "chg0_w1c_vs_event");
    // disabling the interrupt drops IRQ but keeps CHG
    wr(8'h84, 8'h02);
    chk_irq("irq_before_disable", 1'b1);
    cyc(1);
    chk_irq("irq_disabled_drop", 1'b0);
    rd(8'h82, 8'h04, "chg0_after_disable");
    // reset mid-debounce with a pending IRQ
    wr(8'h84, 8'h03);
    wr(8'h82, 8'hFF);
    sw = 16'hA707;
    cyc(20);
    chk_irq("irq_bank1", 1'b1);
    rd(8'h83, 8'h02, "chg1_rise");
    sw = 16'h5A3C;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_irq("irq_after_rst", 1'b0);
    rd(8'h80, 8'h00, "rst2_val0");
    rd(8'h81, 8'h00, "rst2_val1");
    rd(8'h82, 8'h00, "rst2_chg0");
    rd(8'h83, 8'h00, "rst2_chg1");
    rd(8'h84, 8'h00, "rst2_ctrl");
    cyc(20);
    rd(8'h80, 8'h3C, "reload_val0");
    rd(8'h81, 8'h5A, "reload_val1");
    rd(8'h82, 8'h00, "reload_chg0");
    rd(8'h83, 8'h00, "reload_chg1");
    chk_irq("reload_irq", 1'b0);
    cyc(3);
    chk("scoreboard_drain", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
